// File: rtl/fan_speed_sequencer_pkg.sv
// +----------------------------------------------------------------------+
// | fan_ctrl_pkg - shared types and level->duty map for the fan sequencer |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package fan_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } fan_state_e;

  typedef logic [1:0] level_t;

  localparam int unsigned LVL1_DUTY_DEF = 64;
  localparam int unsigned LVL2_DUTY_DEF = 128;
  localparam int unsigned LVL3_DUTY_DEF = 255;

  function automatic int unsigned level_duty(level_t lvl, int unsigned l1,
                                             int unsigned l2, int unsigned l3);
    int unsigned res;
    case (lvl)
      2'd1:    res = l1;
      2'd2:    res = l2;
      2'd3:    res = l3;
      default: res = 0;
    endcase
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fan_speed_sequencer_if.sv
// +----------------------------------------------------------------------+
// | fan_speed_sequencer_if - command inputs and status outputs, rev 1.0   |
// +----------------------------------------------------------------------+
`default_nettype none

interface fan_speed_sequencer_if #(
  parameter int unsigned DUTY_W  = 8,
  parameter int unsigned TIMER_W = 12
);
  logic               cfg_wr;
  logic [1:0]         cfg_level;
  logic [TIMER_W-1:0] cfg_timer_s;
  logic               btn_next;
  logic               estop;
  logic [DUTY_W-1:0]  duty;
  logic               pwm_en;
  logic [1:0]         state;
  logic [1:0]         level;
  logic [TIMER_W-1:0] timer_remain;
  logic               done_pulse;

  modport master (
    output cfg_wr, cfg_level, cfg_timer_s, btn_next, estop,
    input  duty, pwm_en, state, level, timer_remain, done_pulse
  );

  modport slave (
    input  cfg_wr, cfg_level, cfg_timer_s, btn_next, estop,
    output duty, pwm_en, state, level, timer_remain, done_pulse
  );
endinterface

`default_nettype wire

// File: rtl/fan_speed_sequencer_tick_gen.sv
// +----------------------------------------------------------------------+
// | fan_tick_gen - 1-cycle tick every PERIOD enabled cycles, rev 1.0      |
// +----------------------------------------------------------------------+
`default_nettype none

module fan_tick_gen #(
  parameter int unsigned PERIOD = 4
) (
  input  wire  clk,
  input  wire  rst,
  input  wire  clr,
  input  wire  en,
  output logic tick
);
  localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

`default_nettype wire

// File: rtl/fan_speed_sequencer.sv
// +----------------------------------------------------------------------+
// | fan_speed_sequencer - soft start/stop duty ramp with auto-off timer   |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module fan_speed_sequencer
  import fan_ctrl_pkg::*;
#(
  parameter int unsigned DUTY_W        = 8,
  parameter int unsigned TIMER_W       = 12,
  parameter int unsigned RAMP_STEP_CYC = 100_000,
  parameter int unsigned RAMP_INC      = 16,
  parameter int unsigned SEC_CYC       = 100_000_000,
  parameter int unsigned LVL1_DUTY     = LVL1_DUTY_DEF,
  parameter int unsigned LVL2_DUTY     = LVL2_DUTY_DEF,
  parameter int unsigned LVL3_DUTY     = LVL3_DUTY_DEF
) (
  input wire                    clk,
  input wire                    reset_p,
  fan_speed_sequencer_if.slave  bus
);
  localparam logic [DUTY_W-1:0] INC = DUTY_W'(RAMP_INC);

  logic [DUTY_W-1:0]  duty_q, duty_d;
  fan_state_e         state_q, state_d;
  level_t             level_q, level_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               pwm_en_q, pwm_en_d;
  logic               done_q, done_d;
  logic               exp_stop_q, exp_stop_d;

  logic               ramp_clr, ramp_en, ramp_tick;
  logic               sec_clr, sec_en, sec_tick;
  logic [DUTY_W-1:0]  step_tgt, step_diff, step_duty;

  function automatic logic [DUTY_W-1:0] tgt_of(level_t l);
    return DUTY_W'(level_duty(l, LVL1_DUTY, LVL2_DUTY, LVL3_DUTY));
  endfunction

  // State after a new level command, judged against the duty currently driven.
  function automatic fan_state_e cmd_state(level_t l, logic [DUTY_W-1:0] d);
    fan_state_e s;
    if (l != 2'd0)
      s = (d != tgt_of(l)) ? ST_RAMP : ST_RUN;
    else
      s = (d != '0) ? ST_STOP : ST_IDLE;
    return s;
  endfunction

  assign ramp_en = (state_q == ST_RAMP) || (state_q == ST_STOP);
  assign sec_en  = (timer_q != '0) && ((state_q == ST_RAMP) || (state_q == ST_RUN));

  fan_tick_gen #(.PERIOD(RAMP_STEP_CYC)) u_ramp_tick (
    .clk  (clk),
    .rst  (reset_p),
    .clr  (ramp_clr),
    .en   (ramp_en),
    .tick (ramp_tick)
  );

  fan_tick_gen #(.PERIOD(SEC_CYC)) u_sec_tick (
    .clk  (clk),
    .rst  (reset_p),
    .clr  (sec_clr),
    .en   (sec_en),
    .tick (sec_tick)
  );

  always_comb begin
    step_tgt = (state_q == ST_STOP) ? '0 : tgt_of(level_q);
    if (step_tgt > duty_q) begin
      step_diff = step_tgt - duty_q;
      step_duty = duty_q + ((step_diff > INC) ? INC : step_diff);
    end else begin
      step_diff = duty_q - step_tgt;
      step_duty = duty_q - ((step_diff > INC) ? INC : step_diff);
    end
  end

  always_comb begin
    duty_d     = duty_q;
    state_d    = state_q;
    level_d    = level_q;
    timer_d    = timer_q;
    exp_stop_d = exp_stop_q;
    done_d     = 1'b0;
    ramp_clr   = 1'b0;
    sec_clr    = 1'b0;

    if (bus.estop) begin
      duty_d     = '0;
      state_d    = ST_IDLE;
      level_d    = 2'd0;
      timer_d    = '0;
      exp_stop_d = 1'b0;
      ramp_clr   = 1'b1;
      sec_clr    = 1'b1;
    end else if (bus.cfg_wr) begin
      level_d    = bus.cfg_level;
      timer_d    = bus.cfg_timer_s;
      state_d    = cmd_state(bus.cfg_level, duty_q);
      exp_stop_d = 1'b0;
      ramp_clr   = 1'b1;
      sec_clr    = 1'b1;
    end else if (bus.btn_next) begin
      level_d    = level_q + 2'd1;
      state_d    = cmd_state(level_q + 2'd1, duty_q);
      exp_stop_d = 1'b0;
      ramp_clr   = 1'b1;
    end else if (sec_tick && (timer_q == TIMER_W'(1))) begin
      timer_d    = '0;
      level_d    = 2'd0;
      state_d    = ST_STOP;
      exp_stop_d = 1'b1;
      ramp_clr   = 1'b1;
    end else begin
      if (sec_tick)
        timer_d = timer_q - TIMER_W'(1);
      if (ramp_tick)
        duty_d = step_duty;
      if ((state_q == ST_RAMP) && (duty_d == tgt_of(level_q)))
        state_d = ST_RUN;
      // Only a timer-initiated stop reports completion.
      if ((state_q == ST_STOP) && (duty_d == '0)) begin
        state_d    = ST_IDLE;
        done_d     = exp_stop_q;
        exp_stop_d = 1'b0;
      end
    end

    pwm_en_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      duty_q     <= '0;
      state_q    <= ST_IDLE;
      level_q    <= 2'd0;
      timer_q    <= '0;
      pwm_en_q   <= 1'b0;
      done_q     <= 1'b0;
      exp_stop_q <= 1'b0;
    end else begin
      duty_q     <= duty_d;
      state_q    <= state_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      pwm_en_q   <= pwm_en_d;
      done_q     <= done_d;
      exp_stop_q <= exp_stop_d;
    end
  end

  assign bus.duty         = duty_q;
  assign bus.pwm_en       = pwm_en_q;
  assign bus.state        = state_q;
  assign bus.level        = level_q;
  assign bus.timer_remain = timer_q;
  assign bus.done_pulse   = done_q;

endmodule

`default_nettype wire
